// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core: architectural states, reset vector, instruction size.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/mips_pc_unit.sv
// Program counter with branch-delay-slot bookkeeping: a taken branch redirects
// the PC only after the instruction that follows it has committed.
module mips_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  logic        capture,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        delay_slot,
  output logic [31:0] next_pc
);

  logic        pend;
  logic [31:0] pend_target;
  logic        cap_held;
  logic        take_now;
  logic [31:0] seq_pc;

  // Branches sitting in a delay slot never arm a redirect.
  assign take_now = capture & branch_taken & ~delay_slot;
  assign seq_pc   = pc + INSTR_BYTES;
  assign next_pc  = pend ? pend_target : seq_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      delay_slot  <= 1'b0;
      pend        <= 1'b0;
      pend_target <= 32'd0;
      cap_held    <= 1'b0;
    end else begin
      if (take_now)
        pend_target <= branch_target;
      if (commit) begin
        pc       <= next_pc;
        cap_held <= 1'b0;
        // The redirect arms only at the branch's own commit, so an EXEC2 branch
        // does not jump before its delay slot.
        if (pend) begin
          pend       <= 1'b0;
          delay_slot <= 1'b0;
        end else if (take_now | cap_held) begin
          pend       <= 1'b1;
          delay_slot <= 1'b1;
        end else begin
          delay_slot <= 1'b0;
        end
      end else if (take_now) begin
        cap_held <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle sequencer: state register, instruction register, commit counter and halt detection.
// state | meaning
// FETCH | waiting for instruction word from memory
// EXEC1 | first execute cycle; branch capture, possible memory stall
// EXEC2 | second execute cycle for instructions flagged extra
// HALT  | control reached address 0; frozen until reset
module mips_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        extra,
  input  logic        mem_op,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [1:0]  state,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        delay_slot,
  output logic        active,
  output logic [31:0] instr_count
);

  state_t      state_q;
  state_t      state_d;
  logic        commit;
  logic        capture;
  logic [31:0] next_pc;

  mips_pc_unit #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clk           (clk),
    .reset         (reset),
    .commit        (commit),
    .capture       (capture),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .delay_slot    (delay_slot),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    capture = 1'b0;
    case (state_q)
      FETCH: if (!waitrequest) state_d = EXEC1;
      EXEC1: begin
        if (!(mem_op && waitrequest)) begin
          capture = 1'b1;
          if (extra) begin
            state_d = EXEC2;
          end else begin
            commit  = 1'b1;
            state_d = (next_pc == 32'd0) ? HALT : FETCH;
          end
        end
      end
      EXEC2: begin
        commit  = 1'b1;
        state_d = (next_pc == 32'd0) ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (state_q == FETCH && !waitrequest)
        instr <= readdata;
      if (commit)
        instr_count <= instr_count + 32'd1;
    end
  end

  assign state  = state_q;
  assign active = (state_q != HALT);

endmodule
